// File: rtl/hazard_detect_unit.sv
// rtl/hazard_detect_unit.sv - load-use and redirect stall request generator with saturating stall counters
module hazard_detect_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             valid_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             uses_rs1_d,
    input  logic             uses_rs2_d,
    input  logic             valid_e,
    input  logic [4:0]       rd_e,
    input  logic             mem_read_e,
    input  logic             redirect_e,
    output logic             stall_lw,
    output logic             stall_j,
    output logic [CNT_W-1:0] lw_stall_cnt,
    output logic [CNT_W-1:0] j_stall_cnt
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_GAP = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_pend_j;
    logic [CNT_W-1:0] r_lw_cnt;
    logic [CNT_W-1:0] r_j_cnt;

    logic             w_lu_hit;
    logic             w_rd_hit;
    logic             w_stall_lw;
    logic             w_stall_j;

    // Hazard terms from the live pipeline-register contents; x0 is never a real dependency
    always_comb begin
        w_lu_hit = valid_d & valid_e & mem_read_e & (rd_e != 5'd0) &
                   ((uses_rs1_d & (rs1_d == rd_e)) | (uses_rs2_d & (rs2_d == rd_e)));
        w_rd_hit = valid_e & redirect_e;
    end

    // Mealy requests: only RUN may issue, redirect wins since decode is on the wrong path, held low in reset
    always_comb begin
        w_stall_lw = 1'b0;
        w_stall_j  = 1'b0;
        if (reset_n && (r_state == ST_RUN)) begin
            if (w_rd_hit || r_pend_j) begin
                w_stall_j = 1'b1;
            end else if (w_lu_hit) begin
                w_stall_lw = 1'b1;
            end
        end
    end

    // Pulse shaper: every request is followed by one GAP cycle; a redirect seen in GAP is deferred, not lost
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_pend_j <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_stall_j || w_stall_lw) begin
                        r_state <= ST_GAP;
                    end
                    if (w_stall_j) begin
                        r_pend_j <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_RUN;
                    if (w_rd_hit) begin
                        r_pend_j <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating performance counters, one per request type
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lw_cnt <= '0;
            r_j_cnt  <= '0;
        end else begin
            if (w_stall_lw && (r_lw_cnt != CNT_MAX)) begin
                r_lw_cnt <= r_lw_cnt + CNT_ONE;
            end
            if (w_stall_j && (r_j_cnt != CNT_MAX)) begin
                r_j_cnt <= r_j_cnt + CNT_ONE;
            end
        end
    end

    assign stall_lw     = w_stall_lw;
    assign stall_j      = w_stall_j;
    assign lw_stall_cnt = r_lw_cnt;
    assign j_stall_cnt  = r_j_cnt;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb/tb_hazard_detect_unit.sv - scoreboard bench for hazard_detect_unit with directed vectors
module tb_hazard_detect_unit;

    localparam int CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             valid_d;
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic             uses_rs1_d;
    logic             uses_rs2_d;
    logic             valid_e;
    logic [4:0]       rd_e;
    logic             mem_read_e;
    logic             redirect_e;
    logic             stall_lw;
    logic             stall_j;
    logic [CNT_W-1:0] lw_stall_cnt;
    logic [CNT_W-1:0] j_stall_cnt;

    typedef struct {
        string name;
        int    lw;
        int    j;
        int    lc;
        int    jc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_detect_unit #(.CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .valid_d      (valid_d),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .uses_rs1_d   (uses_rs1_d),
        .uses_rs2_d   (uses_rs2_d),
        .valid_e      (valid_e),
        .rd_e         (rd_e),
        .mem_read_e   (mem_read_e),
        .redirect_e   (redirect_e),
        .stall_lw     (stall_lw),
        .stall_j      (stall_j),
        .lw_stall_cnt (lw_stall_cnt),
        .j_stall_cnt  (j_stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: each cycle's outputs are compared at the falling edge against the oldest expectation
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.name, ".stall_lw"}, int'(stall_lw), e.lw);
            chk({e.name, ".stall_j"},  int'(stall_j),  e.j);
            chk({e.name, ".lw_cnt"},   int'(lw_stall_cnt), e.lc);
            chk({e.name, ".j_cnt"},    int'(j_stall_cnt),  e.jc);
        end
    end

    task automatic set_in(input logic vd, input logic u1, input logic u2,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic ve, input logic [4:0] rd,
                          input logic mr, input logic rj);
        valid_d    = vd;
        uses_rs1_d = u1;
        uses_rs2_d = u2;
        rs1_d      = r1;
        rs2_d      = r2;
        valid_e    = ve;
        rd_e       = rd;
        mem_read_e = mr;
        redirect_e = rj;
    endtask

    task automatic push(input string name, input int lw, input int j, input int lc, input int jc);
        exp_t e;
        e.name = name;
        e.lw   = lw;
        e.j    = j;
        e.lc   = lc;
        e.jc   = jc;
        exp_q.push_back(e);
    endtask

    task automatic cyc_idle(input string name, input int lw, input int j, input int lc, input int jc);
        @(posedge clock);
        #1;
        set_in(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        push(name, lw, j, lc, jc);
    endtask

    // Load in execute writing x5 while decode reads rs1=x5
    task automatic cyc_lu(input string name, input int lw, input int j, input int lc, input int jc);
        @(posedge clock);
        #1;
        set_in(1, 1, 0, 5'd5, 5'd0, 1, 5'd5, 1, 0);
        push(name, lw, j, lc, jc);
    endtask

    task automatic cyc_redir(input string name, input int lw, input int j, input int lc, input int jc);
        @(posedge clock);
        #1;
        set_in(0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 1);
        push(name, lw, j, lc, jc);
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk({name, ".rst_lw_cnt"}, int'(lw_stall_cnt), 0);
        chk({name, ".rst_j_cnt"},  int'(j_stall_cnt), 0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset.stall_lw", int'(stall_lw), 0);
        chk("reset.stall_j",  int'(stall_j), 0);
        chk("reset.lw_cnt",   int'(lw_stall_cnt), 0);
        chk("reset.j_cnt",    int'(j_stall_cnt), 0);
        #10;
        reset_n = 1'b1;

        // Load-use held three cycles: pulse, gap, pulse
        cyc_lu  ("lu.c0", 1, 0, 0, 0);
        cyc_lu  ("lu.c1", 0, 0, 1, 0);
        cyc_lu  ("lu.c2", 1, 0, 1, 0);
        cyc_idle("lu.c3", 0, 0, 2, 0);
        cyc_idle("lu.c4", 0, 0, 2, 0);

        // rd_e = x0 never hits; matching rd without a source use never hits
        @(posedge clock); #1; set_in(1, 1, 0, 5'd0, 5'd0, 1, 5'd0, 1, 0); push("x0.c0", 0, 0, 2, 0);
        @(posedge clock); #1; set_in(1, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0); push("x0.c1", 0, 0, 2, 0);
        @(posedge clock); #1; set_in(1, 0, 0, 5'd5, 5'd5, 1, 5'd5, 1, 0); push("nouse.c0", 0, 0, 2, 0);
        @(posedge clock); #1; set_in(1, 0, 0, 5'd5, 5'd5, 1, 5'd5, 1, 0); push("nouse.c1", 0, 0, 2, 0);
        // rs2 match alone still hits
        @(posedge clock); #1; set_in(1, 0, 1, 5'd0, 5'd9, 1, 5'd9, 1, 0); push("rs2.c0", 1, 0, 2, 0);
        cyc_idle("rs2.c1", 0, 0, 3, 0);

        // Redirect and load-use together: redirect wins
        do_reset("prio");
        @(posedge clock); #1; set_in(1, 1, 0, 5'd5, 5'd0, 1, 5'd5, 1, 1); push("prio.c0", 0, 1, 0, 0);
        cyc_idle("prio.c1", 0, 0, 0, 1);
        cyc_idle("prio.c2", 0, 0, 0, 1);

        // Redirect in GAP is deferred by exactly one cycle
        do_reset("pend");
        cyc_lu   ("pend.c0", 1, 0, 0, 0);
        cyc_redir("pend.c1", 0, 0, 1, 0);
        cyc_idle ("pend.c2", 0, 1, 1, 0);
        cyc_idle ("pend.c3", 0, 0, 1, 1);
        cyc_idle ("pend.c4", 0, 0, 1, 1);

        // Pending redirect plus a live redirect in RUN merge into one pulse
        do_reset("merge");
        cyc_lu   ("merge.c0", 1, 0, 0, 0);
        cyc_redir("merge.c1", 0, 0, 1, 0);
        cyc_redir("merge.c2", 0, 1, 1, 0);
        cyc_idle ("merge.c3", 0, 0, 1, 1);
        cyc_idle ("merge.c4", 0, 0, 1, 1);

        // A load-use seen only in GAP is forgotten
        do_reset("lugap");
        cyc_lu  ("lugap.c0", 1, 0, 0, 0);
        @(posedge clock); #1; set_in(1, 0, 1, 5'd0, 5'd7, 1, 5'd7, 1, 0); push("lugap.c1", 0, 0, 1, 0);
        cyc_idle("lugap.c2", 0, 0, 1, 0);
        cyc_idle("lugap.c3", 0, 0, 1, 0);

        // Saturation of the 2-bit redirect counter
        do_reset("sat");
        for (int k = 0; k < 6; k++) begin
            cyc_redir($sformatf("sat.r%0d", k), 0, 1, 0, (k < 3) ? k : 3);
            cyc_idle ($sformatf("sat.g%0d", k), 0, 0, 0, (k + 1 < 3) ? k + 1 : 3);
        end

        // Asynchronous reset while a pending redirect is being issued
        do_reset("arst");
        cyc_redir("arst.c0", 0, 1, 0, 0);
        cyc_redir("arst.c1", 0, 0, 0, 1);
        @(posedge clock);
        #1;
        set_in(0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 1);
        chk("arst.pre_stall_j", int'(stall_j), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst.stall_j", int'(stall_j), 0);
        chk("arst.stall_lw", int'(stall_lw), 0);
        chk("arst.lw_cnt", int'(lw_stall_cnt), 0);
        chk("arst.j_cnt", int'(j_stall_cnt), 0);
        #1;
        set_in(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        reset_n = 1'b1;
        cyc_idle("arst.c3", 0, 0, 0, 0);
        cyc_idle("arst.c4", 0, 0, 0, 0);

        @(negedge clock);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
